// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: write-only engine for the 16x2 LCD 4-bit bus (high/low nibble, E timing, gaps).
// Define LCD_XFER_COUNT_EN to add the oXferCount completed-transfer counter output.
module lcd_nibble_writer #(
    parameter int SETUP_CYC      = 2,
    parameter int PULSE_CYC      = 12,
    parameter int HOLD_CYC       = 1,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int BYTE_GAP_CYC   = 2000,
    parameter int LONG_GAP_CYC   = 82000,
    parameter int CNT_W          = 17
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  iData,
    input  logic        iRS,
    input  logic        iNibbleOnly,
    input  logic        iValid,
    output logic        oReady,
    output logic        oDone,
    output logic        oLCD_Enabled,
    output logic        oLCD_RegisterSelect,
    output logic        oLCD_ReadWrite,
    output logic        oLCD_StrataFlashControl,
    output logic [3:0]  oLCD_Data
`ifdef LCD_XFER_COUNT_EN
    ,
    output logic [15:0] oXferCount
`endif
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] SETUP_HI = 4'd1;
    localparam logic [3:0] PULSE_HI = 4'd2;
    localparam logic [3:0] HOLD_HI  = 4'd3;
    localparam logic [3:0] GAP_NIB  = 4'd4;
    localparam logic [3:0] SETUP_LO = 4'd5;
    localparam logic [3:0] PULSE_LO = 4'd6;
    localparam logic [3:0] HOLD_LO  = 4'd7;
    localparam logic [3:0] GAP_END  = 4'd8;

    // Counter reload values: a state lasting N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] NGAP_LD  = CNT_W'(NIBBLE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] BGAP_LD  = CNT_W'(BYTE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LGAP_LD  = CNT_W'(LONG_GAP_CYC - 1);

    logic [3:0]       stateReg, stateNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic [3:0]       dataReg, dataNext;
    logic [3:0]       lowNibReg, lowNibNext;
    logic             rsReg, rsNext;
    logic             longGapReg, longGapNext;
    logic             enReg, enNext;
    logic             doneReg, doneNext;
    logic             expired;
    logic             isClearHome;

    assign expired     = (cntReg == '0);
    assign isClearHome = (iData == 8'h01) || (iData == 8'h02) || (iData == 8'h03);

    always_comb begin
        stateNext   = stateReg;
        cntNext     = expired ? cntReg : cntReg - CNT_W'(1);
        dataNext    = dataReg;
        lowNibNext  = lowNibReg;
        rsNext      = rsReg;
        longGapNext = longGapReg;
        doneNext    = 1'b0;
        case (stateReg)
            IDLE: begin
                cntNext = '0;
                if (iValid) begin
                    rsNext      = iRS;
                    lowNibNext  = iData[3:0];
                    longGapNext = !iRS && !iNibbleOnly && isClearHome;
                    cntNext     = SETUP_LD;
                    if (iNibbleOnly) begin
                        stateNext = SETUP_LO;
                        dataNext  = iData[3:0];
                    end else begin
                        stateNext = SETUP_HI;
                        dataNext  = iData[7:4];
                    end
                end
            end
            SETUP_HI: begin
                if (expired) begin
                    stateNext = PULSE_HI;
                    cntNext   = PULSE_LD;
                end
            end
            PULSE_HI: begin
                if (expired) begin
                    stateNext = HOLD_HI;
                    cntNext   = HOLD_LD;
                end
            end
            HOLD_HI: begin
                if (expired) begin
                    stateNext = GAP_NIB;
                    cntNext   = NGAP_LD;
                end
            end
            GAP_NIB: begin
                // High nibble stays on the bus through the gap; swap only on SETUP_LO entry.
                if (expired) begin
                    stateNext = SETUP_LO;
                    cntNext   = SETUP_LD;
                    dataNext  = lowNibReg;
                end
            end
            SETUP_LO: begin
                if (expired) begin
                    stateNext = PULSE_LO;
                    cntNext   = PULSE_LD;
                end
            end
            PULSE_LO: begin
                if (expired) begin
                    stateNext = HOLD_LO;
                    cntNext   = HOLD_LD;
                end
            end
            HOLD_LO: begin
                if (expired) begin
                    stateNext = GAP_END;
                    cntNext   = longGapReg ? LGAP_LD : BGAP_LD;
                end
            end
            GAP_END: begin
                if (expired) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                    dataNext  = 4'h0;
                    rsNext    = 1'b0;
                    doneNext  = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
                dataNext  = 4'h0;
                rsNext    = 1'b0;
            end
        endcase
        // E is a registered decode of the next state so it never glitches.
        enNext = (stateNext == PULSE_HI) || (stateNext == PULSE_LO);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stateReg   <= IDLE;
            cntReg     <= '0;
            dataReg    <= 4'h0;
            lowNibReg  <= 4'h0;
            rsReg      <= 1'b0;
            longGapReg <= 1'b0;
            enReg      <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            cntReg     <= cntNext;
            dataReg    <= dataNext;
            lowNibReg  <= lowNibNext;
            rsReg      <= rsNext;
            longGapReg <= longGapNext;
            enReg      <= enNext;
            doneReg    <= doneNext;
        end
    end

`ifdef LCD_XFER_COUNT_EN
    logic [15:0] xferCountReg;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            xferCountReg <= 16'h0000;
        end else if (doneNext) begin
            xferCountReg <= xferCountReg + 16'd1;
        end
    end

    assign oXferCount = xferCountReg;
`endif

    assign oReady                  = (stateReg == IDLE);
    assign oDone                   = doneReg;
    assign oLCD_Enabled            = enReg;
    assign oLCD_RegisterSelect     = rsReg;
    assign oLCD_Data               = dataReg;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

endmodule
